// File: rtl/marquee_pkg.sv
// Shared types and default geometry for the text marquee controller.
package marquee_pkg;

  localparam int PITCH  = 64;
  localparam int X0     = 158;
  localparam int GLYPHW = 7;

  typedef enum logic {
    HOLD,
    SCROLL
  } state_t;

  typedef logic [GLYPHW-1:0] glyph_t;

endpackage

// File: rtl/marquee_ctrl.sv
// Per-frame marquee: scrolls a SPR_CNT-glyph window across a message held in
// registers, pausing at the start of each pass; outputs are frame-stable.
module marquee_ctrl #(
  parameter int CORDW        = 16,
  parameter int SPR_CNT      = 5,
  parameter int MSG_LEN      = 8,
  parameter int GLYPHW       = marquee_pkg::GLYPHW,
  parameter int PITCH        = marquee_pkg::PITCH,
  parameter int X0           = marquee_pkg::X0,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic                            clk_pix,
  input  logic                            rst_pix_n,
  input  logic                            frame,
  input  logic                            en,
  input  logic [3:0]                      step,
  input  logic                            wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]      wr_addr,
  input  logic [GLYPHW-1:0]               wr_data,
  output logic signed [CORDW-1:0]         spr_x  [SPR_CNT],
  output logic [GLYPHW-1:0]               spr_cp [SPR_CNT],
  output logic                            paused
);

  import marquee_pkg::*;

  localparam int AW = $clog2(MSG_LEN);
  localparam int OW = $clog2(PITCH);
  localparam int CW = (PAUSE_FRAMES > 0) ? $clog2(PAUSE_FRAMES + 1) : 1;

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [AW-1:0]           r_idx, w_idx_nx, w_idx_inc;
  logic [OW-1:0]           r_ofs, w_ofs_nx;
  logic [OW:0]             w_sum;
  logic                    w_adv, w_wr_ok;

  logic [GLYPHW-1:0]       r_msg    [MSG_LEN];
  logic signed [CORDW-1:0] r_spr_x  [SPR_CNT];
  logic signed [CORDW-1:0] w_x_nx   [SPR_CNT];
  logic [GLYPHW-1:0]       r_spr_cp [SPR_CNT];
  logic [GLYPHW-1:0]       w_cp_nx  [SPR_CNT];
  logic [AW:0]             w_slot   [SPR_CNT];
  logic                    r_paused;

  assign w_adv   = frame & en;
  assign w_wr_ok = wr_en && (32'(wr_addr) < 32'(MSG_LEN));

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_state <= HOLD;
      r_cnt   <= CW'(PAUSE_FRAMES);
      r_idx   <= '0;
      r_ofs   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_ofs   <= w_ofs_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_ofs_nx   = r_ofs;
    // step < PITCH, so one subtraction always brings the sum back into range
    w_sum      = {1'b0, r_ofs} + (OW+1)'(step);
    w_idx_inc  = (r_idx == AW'(MSG_LEN - 1)) ? '0 : r_idx + AW'(1);
    if (w_adv) begin
      case (r_state)
        HOLD: begin
          w_ofs_nx = '0;
          if (r_cnt == '0) w_state_nx = SCROLL;
          else             w_cnt_nx   = r_cnt - CW'(1);
        end
        SCROLL: begin
          if (w_sum >= (OW+1)'(PITCH)) begin
            w_ofs_nx = OW'(w_sum - (OW+1)'(PITCH));
            w_idx_nx = w_idx_inc;
            if (w_idx_inc == '0) begin
              w_state_nx = HOLD;
              w_cnt_nx   = CW'(PAUSE_FRAMES);
              w_ofs_nx   = '0;
            end
          end else begin
            w_ofs_nx = OW'(w_sum);
          end
        end
      endcase
    end
  end

  // Slot outputs come from next-state idx/ofs but pre-write message contents.
  always_comb begin
    for (int unsigned i = 0; i < SPR_CNT; i++) begin
      w_slot[i] = (AW+1)'(w_idx_nx) + (AW+1)'(i);
      if (w_slot[i] >= (AW+1)'(MSG_LEN)) w_slot[i] = w_slot[i] - (AW+1)'(MSG_LEN);
      w_cp_nx[i] = r_msg[w_slot[i][AW-1:0]];
      w_x_nx[i]  = CORDW'(X0 + int'(i) * PITCH - int'(w_ofs_nx));
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_paused <= 1'b1;
      for (int unsigned m = 0; m < MSG_LEN; m++) r_msg[m] <= '0;
      for (int unsigned i = 0; i < SPR_CNT; i++) begin
        r_spr_x[i]  <= CORDW'(X0 + int'(i) * PITCH);
        r_spr_cp[i] <= '0;
      end
    end else begin
      if (w_adv) begin
        r_paused <= (w_state_nx == HOLD);
        for (int unsigned i = 0; i < SPR_CNT; i++) begin
          r_spr_x[i]  <= w_x_nx[i];
          r_spr_cp[i] <= w_cp_nx[i];
        end
      end
      if (w_wr_ok) r_msg[wr_addr] <= wr_data;
    end
  end

  assign spr_x  = r_spr_x;
  assign spr_cp = r_spr_cp;
  assign paused = r_paused;

endmodule

// File: tb/tb_marquee_ctrl.sv
// Self-checking bench for marquee_ctrl: vector table, directed corner cases
// and random stimulus against a pixel-position reference model.
module tb_marquee_ctrl;

  localparam int SPR   = 5;
  localparam int MLEN  = 8;
  localparam int PITCH = 64;
  localparam int X0    = 158;
  localparam int PAUSE = 60;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic              rst_pix_n, frame, en, wr_en;
  logic [3:0]        step;
  logic [2:0]        wr_addr;
  logic [6:0]        wr_data;
  logic signed [15:0] spr_x [SPR];
  logic [6:0]        spr_cp [SPR];
  logic              paused;

  logic              b_frame, b_en, b_wr_en;
  logic [3:0]        b_step;
  logic [2:0]        b_wr_addr;
  logic [6:0]        b_wr_data;
  logic signed [15:0] b_spr_x [SPR];
  logic [6:0]        b_spr_cp [SPR];
  logic              b_paused;

  marquee_ctrl #(
    .CORDW(16), .SPR_CNT(SPR), .MSG_LEN(MLEN), .GLYPHW(7),
    .PITCH(PITCH), .X0(X0), .PAUSE_FRAMES(PAUSE)
  ) u_dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .en(en),
    .step(step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .spr_x(spr_x), .spr_cp(spr_cp), .paused(paused)
  );

  // Six-entry message: exercises the out-of-range write guard and non-power-of-2 length.
  marquee_ctrl #(
    .CORDW(16), .SPR_CNT(SPR), .MSG_LEN(6), .GLYPHW(7),
    .PITCH(PITCH), .X0(X0), .PAUSE_FRAMES(PAUSE)
  ) u_dut6 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(b_frame), .en(b_en),
    .step(b_step), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .spr_x(b_spr_x), .spr_cp(b_spr_cp), .paused(b_paused)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference model: scroll position in pixels since the start of the pass.
  int m_msg [MLEN];
  int m_pos, m_left;
  bit m_hold;
  int e_x [SPR];
  int e_cp [SPR];
  int e_paused;

  function automatic void m_reset();
    for (int k = 0; k < MLEN; k++) m_msg[k] = 0;
    m_pos = 0; m_hold = 1'b1; m_left = PAUSE;
    for (int i = 0; i < SPR; i++) begin
      e_x[i] = X0 + i * PITCH;
      e_cp[i] = 0;
    end
    e_paused = 1;
  endfunction

  function automatic void m_clock();
    if (!rst_pix_n) begin
      m_reset();
      return;
    end
    if (frame && en) begin
      if (m_hold) begin
        if (m_left == 0) m_hold = 1'b0;
        else             m_left--;
      end else begin
        m_pos += int'(step);
        if (m_pos >= MLEN * PITCH) begin
          m_pos = 0; m_hold = 1'b1; m_left = PAUSE;
        end
      end
      for (int i = 0; i < SPR; i++) begin
        e_x[i]  = X0 + i * PITCH - (m_pos % PITCH);
        e_cp[i] = m_msg[(m_pos / PITCH + i) % MLEN];
      end
      e_paused = m_hold ? 1 : 0;
    end
    if (wr_en && int'(wr_addr) < MLEN) m_msg[wr_addr] = int'(wr_data);
  endfunction

  task automatic check_model();
    for (int i = 0; i < SPR; i++) begin
      chk($sformatf("model_x[%0d]", i), int'(spr_x[i]), e_x[i]);
      chk($sformatf("model_cp[%0d]", i), int'(spr_cp[i]), e_cp[i]);
    end
    chk("model_paused", int'(paused), e_paused);
  endtask

  task automatic cycle();
    @(posedge clk_pix);
    m_clock();
    #1;
    check_model();
  endtask

  task automatic adv();
    frame = 1'b1; en = 1'b1;
    cycle();
    frame = 1'b0;
    cycle();
  endtask

  typedef struct {
    int frame, en, stp, wen, wa, wd;
    int x0, x4, cp0, cp1, ps;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int  n;
    bit  done;
    bit  fprev;

    vecs[0]  = '{0,0,4,1,0,'h12, 158,414,0,0,1};
    vecs[1]  = '{0,0,4,1,1,'h52, 158,414,0,0,1};
    vecs[2]  = '{0,0,4,1,2,'h2A, 158,414,0,0,1};
    vecs[3]  = '{0,0,4,1,3,'h20, 158,414,0,0,1};
    vecs[4]  = '{0,0,4,1,4,'h2E, 158,414,0,0,1};
    vecs[5]  = '{1,1,4,0,0,0,    158,414,'h12,'h52,1};
    vecs[6]  = '{0,0,4,0,0,0,    158,414,'h12,'h52,1};
    vecs[7]  = '{1,0,4,0,0,0,    158,414,'h12,'h52,1};
    vecs[8]  = '{0,0,4,0,0,0,    158,414,'h12,'h52,1};
    vecs[9]  = '{1,1,4,1,1,'h55, 158,414,'h12,'h52,1};
    vecs[10] = '{0,0,4,0,0,0,    158,414,'h12,'h52,1};
    vecs[11] = '{1,1,4,0,0,0,    158,414,'h12,'h55,1};
    vecs[12] = '{0,0,4,1,1,'h52, 158,414,'h12,'h55,1};
    vecs[13] = '{1,1,4,0,0,0,    158,414,'h12,'h52,1};

    rst_pix_n = 1'b0; frame = 1'b0; en = 1'b0; step = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    b_frame = 1'b0; b_en = 1'b0; b_step = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    m_reset();
    cycle();
    cycle();
    rst_pix_n = 1'b1;
    cycle();

    for (int i = 0; i < SPR; i++) begin
      chk($sformatf("rst_x[%0d]", i), int'(spr_x[i]), X0 + i * PITCH);
      chk($sformatf("rst_cp[%0d]", i), int'(spr_cp[i]), 0);
    end
    chk("rst_paused", int'(paused), 1);

    // Six-entry instance: addresses 6 and 7 must not disturb anything.
    for (int a = 7; a >= 0; a--) begin
      b_wr_en = 1'b1; b_wr_addr = 3'(a); b_wr_data = 7'(10 + a);
      cycle();
    end
    b_wr_en = 1'b0; b_frame = 1'b1; b_en = 1'b1;
    cycle();
    b_frame = 1'b0;
    cycle();
    for (int i = 0; i < SPR; i++)
      chk($sformatf("len6_cp[%0d]", i), int'(b_spr_cp[i]), 10 + i);
    chk("len6_paused", int'(b_paused), 1);

    for (int v = 0; v < 14; v++) begin
      frame = 1'(vecs[v].frame); en = 1'(vecs[v].en); step = 4'(vecs[v].stp);
      wr_en = 1'(vecs[v].wen); wr_addr = 3'(vecs[v].wa); wr_data = 7'(vecs[v].wd);
      cycle();
      chk($sformatf("vec%0d_x0", v), int'(spr_x[0]), vecs[v].x0);
      chk($sformatf("vec%0d_x4", v), int'(spr_x[4]), vecs[v].x4);
      chk($sformatf("vec%0d_cp0", v), int'(spr_cp[0]), vecs[v].cp0);
      chk($sformatf("vec%0d_cp1", v), int'(spr_cp[1]), vecs[v].cp1);
      chk($sformatf("vec%0d_paused", v), int'(paused), vecs[v].ps);
    end
    frame = 1'b0; wr_en = 1'b0;

    // Four advances used by the table; 56 more bring the pause counter to zero.
    step = 4'd4;
    repeat (56) adv();
    chk("pause_adv60", int'(paused), 1);
    frame = 1'b1; en = 1'b1;
    cycle();
    chk("pause_fall_T1", int'(paused), 0);
    chk("adv61_x0", int'(spr_x[0]), 158);
    frame = 1'b0;
    cycle();
    adv();
    chk("adv62_x0", int'(spr_x[0]), 154);
    chk("adv62_x4", int'(spr_x[4]), 410);
    repeat (15) adv();
    chk("wrap1_x0", int'(spr_x[0]), 158);
    chk("wrap1_cp0", int'(spr_cp[0]), 'h52);

    step = 4'd15;
    n = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      adv();
      n++;
      if (paused === 1'b1) done = 1'b1;
    end
    chk("pass_done", int'(done), 1);
    chk("pass_advances", n, 30);
    chk("pass_x0", int'(spr_x[0]), 158);
    chk("pass_cp0", int'(spr_cp[0]), 'h12);

    step = 4'd0;
    repeat (61) adv();
    chk("step0_scroll", int'(paused), 0);
    repeat (20) adv();
    chk("step0_stay", int'(paused), 0);
    chk("step0_x0", int'(spr_x[0]), 158);

    step = 4'd5;
    repeat (3) adv();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frame = 1'b1; cycle();
      frame = 1'b0; cycle();
    end
    chk("en0_x0", int'(spr_x[0]), 143);
    chk("en0_paused", int'(paused), 0);

    rst_pix_n = 1'b0; frame = 1'b1; en = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 7'h33;
    cycle();
    chk("midrst_x0", int'(spr_x[0]), 158);
    chk("midrst_x4", int'(spr_x[4]), 414);
    chk("midrst_cp0", int'(spr_cp[0]), 0);
    chk("midrst_paused", int'(paused), 1);
    rst_pix_n = 1'b1; frame = 1'b0; wr_en = 1'b0;
    cycle();
    adv();
    chk("midrst_nowrite", int'(spr_cp[2]), 0);

    fprev = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      rst_pix_n = ($urandom_range(0, 999) != 0);
      frame     = !fprev && ($urandom_range(0, 2) == 0);
      fprev     = frame;
      en        = ($urandom_range(0, 4) != 0);
      step      = 4'($urandom_range(0, 15));
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 7'($urandom_range(0, 85));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
